// File: rtl/controlador_display.sv
// controlador_display: loads a parity-checked symbol message over valid/ready
// and time-multiplexes it across NUM_DIG digits, scrolling long messages.
module controlador_display #(
    parameter int NUM_DIG       = 4,
    parameter int MSG_LEN       = 8,
    parameter int SCAN_DIV      = 1000,
    parameter int SCROLL_FRAMES = 50,
    parameter int PARIDADE_PAR  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [4:0]         codigo,
    input  logic               paridade,
    input  logic               in_valid,
    input  logic               in_last,
    output logic               in_ready,
    input  logic               limpar,
    output logic [4:0]         entrada,
    output logic               erropar,
    output logic [NUM_DIG-1:0] anodo,
    output logic               exibindo,
    output logic [3:0]         erros
);

    localparam int LW = $clog2(MSG_LEN + 1);
    localparam int BW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam int DW = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

    localparam logic [4:0]         BLANK  = 5'd31;
    localparam logic [NUM_DIG-1:0] ANODO0 = NUM_DIG'(1) << (NUM_DIG - 1);

    typedef enum logic [1:0] {
        LIMPO,
        CARREGA,
        EXIBE
    } estado_t;

    estado_t          state, state_nx;
    logic [LW-1:0]    len;
    logic [BW-1:0]    base;
    logic [SW-1:0]    scan_cnt;
    logic [DW-1:0]    dig_idx;
    logic [FW-1:0]    frame_cnt;
    logic [5:0]       mem [MSG_LEN];

    logic             xfer, ok, tick, wrap, scroll, enter_exibe, last_slot, frame_end;
    logic [LW:0]      sum;
    logic [BW-1:0]    rd_idx;
    logic             blank;
    logic [4:0]       entrada_nx;
    logic             erropar_nx;
    logic [NUM_DIG-1:0] anodo_nx;

    assign xfer      = in_valid & in_ready & ~limpar;
    assign ok        = ((^codigo) ^ paridade) == ((PARIDADE_PAR != 0) ? 1'b0 : 1'b1);
    assign tick      = scan_cnt == SW'(SCAN_DIV - 1);
    assign wrap      = tick && (dig_idx == DW'(NUM_DIG - 1));
    assign scroll    = (state == EXIBE) && (len > LW'(NUM_DIG));
    assign last_slot = len == LW'(MSG_LEN - 1);
    assign frame_end = frame_cnt == FW'(SCROLL_FRAMES - 1);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LIMPO;
        else        state <= state_nx;
    end

    // Next-state logic; limpar overrides everything, including a transfer
    always_comb begin
        state_nx = state;
        if (limpar) begin
            state_nx = LIMPO;
        end else begin
            case (state)
                LIMPO, CARREGA: begin
                    if (xfer) state_nx = (in_last || last_slot) ? EXIBE : CARREGA;
                end
                EXIBE:   state_nx = EXIBE;
                default: state_nx = LIMPO;
            endcase
        end
        enter_exibe = (state != EXIBE) && (state_nx == EXIBE);
    end

    // Free-running digit scan; not affected by limpar
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            dig_idx  <= '0;
        end else if (tick) begin
            scan_cnt <= '0;
            dig_idx  <= (dig_idx == DW'(NUM_DIG - 1)) ? '0 : dig_idx + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Message length, error count, frame counter and scroll base
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len       <= '0;
            erros     <= '0;
            base      <= '0;
            frame_cnt <= '0;
        end else if (limpar) begin
            len       <= '0;
            erros     <= '0;
            base      <= '0;
            frame_cnt <= '0;
        end else begin
            if (xfer) begin
                len <= len + 1'b1;
                if (!ok && erros != 4'hF) erros <= erros + 1'b1;
            end
            if (enter_exibe) begin
                base      <= '0;
                frame_cnt <= '0;
            end else if (wrap) begin
                frame_cnt <= frame_end ? '0 : frame_cnt + 1'b1;
                if (scroll && frame_end)
                    base <= (LW'(base) == len - 1'b1) ? '0 : base + 1'b1;
            end
        end
    end

    // Message buffer; contents are meaningless beyond len, so no reset
    always_ff @(posedge clk) begin
        if (xfer) mem[BW'(len)] <= {codigo, ok};
    end

    // Content of the currently selected digit; single subtract suffices since base < len and dig_idx < len
    always_comb begin
        sum    = {1'b0, LW'(base)} + {1'b0, LW'(dig_idx)};
        rd_idx = BW'(dig_idx);
        blank  = LW'(dig_idx) >= len;
        if (scroll) begin
            blank  = 1'b0;
            rd_idx = (sum >= {1'b0, len}) ? BW'(sum - {1'b0, len}) : BW'(sum);
        end
        entrada_nx = blank ? BLANK : mem[rd_idx][5:1];
        erropar_nx = blank ? 1'b1  : mem[rd_idx][0];
        anodo_nx   = ANODO0 >> dig_idx;
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anodo    <= ANODO0;
            entrada  <= BLANK;
            erropar  <= 1'b1;
            in_ready <= 1'b1;
            exibindo <= 1'b0;
        end else begin
            anodo    <= anodo_nx;
            entrada  <= entrada_nx;
            erropar  <= erropar_nx;
            in_ready <= state_nx != EXIBE;
            exibindo <= state_nx == EXIBE;
        end
    end

endmodule

// File: tb/tb_controlador_display.sv
// tb_controlador_display: directed bench for controlador_display with a
// short scan (4 cycles per digit, 2 frames per scroll step).
module tb_controlador_display;

    logic       clk;
    logic       rst_n;
    logic [4:0] codigo;
    logic       paridade;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic       limpar;
    logic [4:0] entrada;
    logic       erropar;
    logic [3:0] anodo;
    logic       exibindo;
    logic [3:0] erros;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned cyc;

    logic [4:0] fr_e [4];
    logic       fr_p [4];

    controlador_display #(
        .NUM_DIG(4),
        .MSG_LEN(8),
        .SCAN_DIV(4),
        .SCROLL_FRAMES(2),
        .PARIDADE_PAR(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .codigo(codigo),
        .paridade(paridade),
        .in_valid(in_valid),
        .in_last(in_last),
        .in_ready(in_ready),
        .limpar(limpar),
        .entrada(entrada),
        .erropar(erropar),
        .anodo(anodo),
        .exibindo(exibindo),
        .erros(erros)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edges since reset release; a frame is 16 cycles, wrapping at multiples of 16
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic confere(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send(input logic [4:0] c, input logic p, input logic last);
        confere("send in_ready", in_ready, 1);
        codigo   = c;
        paridade = p;
        in_last  = last;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic pulse_limpar();
        limpar = 1'b1;
        @(posedge clk);
        #1;
        limpar = 1'b0;
    endtask

    // Sample the four digits of the next full frame, checking the digit select on the way
    task automatic sample_frame();
        int unsigned guard = 0;
        int unsigned w;
        @(posedge clk);
        #1;
        while (cyc % 16 != 0 && guard < 40) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 40) confere("frame sync timeout", guard, 0);
        w = cyc;
        for (int d = 0; d < 4; d++) begin
            while (cyc < w + 4 * d + 2) begin
                @(posedge clk);
                #1;
            end
            @(negedge clk);
            fr_e[d] = entrada;
            fr_p[d] = erropar;
            confere($sformatf("frame anodo d%0d", d), anodo, 4'b1000 >> d);
        end
    endtask

    task automatic expect_frame(input string tag, input int e0, input int e1, input int e2, input int e3,
                                input logic p0, input logic p1, input logic p2, input logic p3);
        sample_frame();
        confere({tag, " d0 entrada"}, fr_e[0], e0);
        confere({tag, " d1 entrada"}, fr_e[1], e1);
        confere({tag, " d2 entrada"}, fr_e[2], e2);
        confere({tag, " d3 entrada"}, fr_e[3], e3);
        confere({tag, " d0 erropar"}, fr_p[0], p0);
        confere({tag, " d1 erropar"}, fr_p[1], p1);
        confere({tag, " d2 erropar"}, fr_p[2], p2);
        confere({tag, " d3 erropar"}, fr_p[3], p3);
    endtask

    task automatic load_ramp();
        logic [4:0] c;
        for (int i = 0; i < 8; i++) begin
            c = 5'(i);
            send(c, ^c, 1'b0);
            if (i == 6) begin
                confere("ramp7 in_ready", in_ready, 1);
                confere("ramp7 exibindo", exibindo, 0);
            end
        end
        confere("ramp8 in_ready", in_ready, 0);
        confere("ramp8 exibindo", exibindo, 1);
    endtask

    initial begin
        int b;
        rst_n    = 1'b1;
        codigo   = '0;
        paridade = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        limpar   = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);

        // 1: reset values and digit walk
        confere("rst anodo", anodo, 4'b1000);
        confere("rst entrada", entrada, 31);
        confere("rst erropar", erropar, 1);
        confere("rst in_ready", in_ready, 1);
        confere("rst exibindo", exibindo, 0);
        confere("rst erros", erros, 0);
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            confere($sformatf("walk k%0d anodo", k), anodo, 4'b1000 >> ((k - 1) / 4));
            confere($sformatf("walk k%0d entrada", k), entrada, 31);
        end

        // 2: short message, static display
        send(5'd0, 1'b0, 1'b0);
        send(5'd5, 1'b0, 1'b0);
        send(5'd19, 1'b1, 1'b1);
        confere("t2 in_ready", in_ready, 0);
        confere("t2 exibindo", exibindo, 1);
        confere("t2 erros", erros, 0);
        expect_frame("t2a", 0, 5, 19, 31, 1, 1, 1, 1);
        repeat (4) sample_frame();
        expect_frame("t2b", 0, 5, 19, 31, 1, 1, 1, 1);

        // 3: single symbol with bad parity
        pulse_limpar();
        confere("t3 clr in_ready", in_ready, 1);
        confere("t3 clr exibindo", exibindo, 0);
        send(5'd7, 1'b0, 1'b1);
        confere("t3 erros", erros, 1);
        expect_frame("t3", 7, 31, 31, 31, 0, 1, 1, 1);

        // 4: full buffer, scrolling through a complete lap and back to base 0
        pulse_limpar();
        confere("t4 clr erros", erros, 0);
        load_ramp();
        for (int j = 0; j < 17; j++) begin
            b = ((j + 1) / 2) % 8;
            expect_frame($sformatf("t4 f%0d", j), b, (b + 1) % 8, (b + 2) % 8, (b + 3) % 8, 1, 1, 1, 1);
        end

        // 5: limpar wins over a simultaneous transfer
        pulse_limpar();
        send(5'd3, 1'b1, 1'b0);
        send(5'd4, 1'b1, 1'b0);
        confere("t5 erros before", erros, 1);
        confere("t5 exibindo before", exibindo, 0);
        codigo   = 5'd9;
        paridade = 1'b0;
        in_valid = 1'b1;
        limpar   = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        limpar   = 1'b0;
        confere("t5 in_ready", in_ready, 1);
        confere("t5 erros", erros, 0);
        confere("t5 exibindo", exibindo, 0);
        expect_frame("t5 blank", 31, 31, 31, 31, 1, 1, 1, 1);
        send(5'd12, 1'b0, 1'b1);
        expect_frame("t5 after", 12, 31, 31, 31, 1, 1, 1, 1);

        // 6: asynchronous reset while scrolling
        pulse_limpar();
        load_ramp();
        for (int j = 0; j < 4; j++) begin
            b = ((j + 1) / 2) % 8;
            expect_frame($sformatf("t6 f%0d", j), b, (b + 1) % 8, (b + 2) % 8, (b + 3) % 8, 1, 1, 1, 1);
        end
        #2 rst_n = 1'b0;
        #1;
        confere("t6 anodo", anodo, 4'b1000);
        confere("t6 entrada", entrada, 31);
        confere("t6 erropar", erropar, 1);
        confere("t6 in_ready", in_ready, 1);
        confere("t6 exibindo", exibindo, 0);
        confere("t6 erros", erros, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/controlador_display.md
Name: controlador_display

Overview:
- Sequencer for the 7-segment mapping stage of the code-display datapath.
- Accepts a message of 5-bit symbol codes, each with a parity bit, over a valid/ready handshake and checks parity on entry.
- Buffers the message and time-multiplexes it across NUM_DIG digits, scrolling when the message is longer than the display.
- Per digit, drives the mapper's `entrada` code and `erropar` flag (1 = parity OK, 0 = show error glyph), plus the digit select.

Parameters:
- NUM_DIG, 4: number of multiplexed digits.
- MSG_LEN, 8: message buffer depth in entries; must be at least NUM_DIG.
- SCAN_DIV, 1000: clock cycles each digit stays selected.
- SCROLL_FRAMES, 50: full scan frames per scroll step.
- PARIDADE_PAR, 1: 1 = even parity, 0 = odd parity.

Ports:
- clk  in  1  single system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- codigo  in  5  symbol code; values 0..19 are glyphs, other values are passed through unchanged.
- paridade  in  1  parity bit accompanying `codigo`.
- in_valid  in  1  `codigo`, `paridade` and `in_last` are valid.
- in_last  in  1  marks the final symbol of the message.
- in_ready  out  1  block can accept a symbol.
- limpar  in  1  synchronous clear of the message.
- entrada  out  5  code to the mapper; 31 means blank.
- erropar  out  1  1 = parity OK or blank; 0 = parity error.
- anodo  out  NUM_DIG  one-hot digit select, active-high; digit 0 is anodo[NUM_DIG-1].
- exibindo  out  1  high in state EXIBE.
- erros  out  4  count of parity errors in the current message; saturates at 15.

Behaviour:
- Reset (async, rst_n=0): state LIMPO, len=0, base=0, scan_cnt=0, dig_idx=0, frame_cnt=0. All outputs registered, with reset values:
  - anodo=one-hot bit NUM_DIG-1
  - entrada=31, erropar=1
  - in_ready=1, exibindo=0, erros=0
- Transfer: a symbol transfers when in_valid=1 and in_ready=1 on a rising edge.
  - Writes entry[len] = {codigo, ok}.
  - ok = (XOR of codigo and paridade) == (PARIDADE_PAR ? 0 : 1).
  - len increments; erros increments (saturating at 15) when ok=0.
- FSM:
  - LIMPO: in_ready=1. First transfer goes to CARREGA, or directly to EXIBE if in_last=1.
  - CARREGA: in_ready=1. A transfer with in_last=1, or the transfer that makes len==MSG_LEN, goes to EXIBE.
  - EXIBE: in_ready=0 and exibindo=1. Entering EXIBE clears base and frame_cnt. in_ready is deasserted on the edge that enters EXIBE, so it reads 0 in the following cycle.
  - Any state, limpar=1: go to LIMPO; len, base, frame_cnt and erros are cleared; in_ready=1 next cycle.
  - limpar has priority over a simultaneous transfer: the symbol is not written.
  - The scan counters (scan_cnt, dig_idx) keep running through limpar.
- Scan:
  - scan_cnt counts 0..SCAN_DIV-1. On a terminal count, dig_idx advances modulo NUM_DIG.
  - When dig_idx wraps to 0, frame_cnt advances modulo SCROLL_FRAMES.
  - Outputs update on the clock edge after the dig_idx change: one cycle latency.
- Digit content for digit i:
  - Scrolling only when state=EXIBE and len>NUM_DIG: index = (base+i) mod len; the message wraps around with no gap.
  - Otherwise base=0 and index = i; if i >= len the digit is blank (entrada=31, erropar=1).
  - Non-blank digit: entrada = entry code, erropar = entry ok.
- Scroll: only when state=EXIBE and len>NUM_DIG. base increments modulo len on the scan tick where dig_idx wraps to 0 and frame_cnt==SCROLL_FRAMES-1.
- During LIMPO and CARREGA, the display shows the entries loaded so far, static, with blanks beyond len.
- Reset mid-operation: immediate return to the reset values; buffer contents are don't-care because len=0.

Test Plan (NUM_DIG=4, MSG_LEN=8, SCAN_DIV=4, SCROLL_FRAMES=2, PARIDADE_PAR=1):
1. Release rst_n with no input.
   -> anodo=1000, entrada=31, erropar=1, in_ready=1, erros=0.
   -> anodo walks 1000, 0100, 0010, 0001, spending 4 cycles at each.
2. Send codes 0/p0, 5/p0, 19/p1, with in_last on the third.
   -> in_ready=0 and exibindo=1 from the next cycle.
   -> Digits show entrada 0, 5, 19, 31, all erropar=1.
   -> Static: no scroll after 64 cycles.
3. Send code 7/p0 with in_last.
   -> Digit 0 shows entrada=7, erropar=0; erros=1.
   -> Digits 1..3 show entrada=31.
4. Send codes 0..7 with correct parity and no in_last.
   -> The 8th transfer enters EXIBE.
   -> Window 0,1,2,3 for 32 cycles, then 1,2,3,4, and so on.
   -> At base=7 the window shows 7,0,1,2; then base wraps to 0.
5. In CARREGA with len=2, assert limpar and in_valid in the same cycle.
   -> No write; state LIMPO; erros=0; all digits blank.
   -> in_ready=1.
6. Pull rst_n low mid-scroll in EXIBE.
   -> All outputs take their reset values asynchronously, before the next clk edge.
